color_run_encoder: RTL and testbench
====================================

Name: color_run_encoder

Overview:
- Downstream stage of the two-state colour Mealy FSM. Consumes the FSM's 2-bit output code stream and run-length encodes it.
- Each maximal run of identical colour codes becomes one (code, length) record.
- Records are buffered in a small FIFO and drained over a valid/ready interface by the statistics/trace logic.

Parameters:
- COUNT_WIDTH, 8: width of the run-length field. Maximum run per record is 2^COUNT_WIDTH-1.
- FIFO_DEPTH, 4: record FIFO entries. Must be a power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset asserted).
- in_code  input  2  colour code from the FSM: 1 = Blue output, 2 = Red output, 0 = idle, 3 = reserved.
- in_valid  input  1  in_code is sampled this cycle.
- flush  input  1  close the current run and emit its record.
- out_code  output  2  code field of the FIFO head record.
- out_len  output  COUNT_WIDTH  length field of the FIFO head record.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head record.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current number of queued records.
- overflow  output  1  sticky: a record was dropped because the FIFO was full.
- err  output  1  sticky: reserved code 3 was sampled.

Behaviour:
- Reset (rst low, asynchronous):
  - State -> IDLE; cur_code=0, cur_len=0.
  - FIFO emptied: out_valid=0, fifo_level=0, out_code=0, out_len=0.
  - overflow=0, err=0.
  - Takes effect immediately, mid-run included; queued records are discarded.
- Sampled symbol: in_valid=1 and flush=0. Code 0 is ignored (no effect on run or length). Code 3 sets err and is otherwise ignored.
- State IDLE:
  - Symbol 1/2 -> RUN with cur_code=symbol, cur_len=1.
  - flush -> no effect.
- State RUN:
  - Same symbol, cur_len < MAX: cur_len+1.
  - Same symbol, cur_len == MAX: push (cur_code, MAX); cur_len=1; stay RUN.
  - Different symbol (1/2): push (cur_code, cur_len); cur_code=new symbol; cur_len=1.
  - flush: push (cur_code, cur_len); -> IDLE; cur_len=0.
- flush has priority. When flush=1, in_valid is ignored that cycle, including any symbol presented.
- At most one push per cycle by construction.
- FIFO:
  - Push is registered. A record is visible on out_valid/out_code/out_len the cycle after the triggering edge.
  - Head outputs are driven from storage; they are 0 when empty.
  - Pop occurs when out_valid && out_ready.
  - Order is strictly first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- Full FIFO:
  - Push with no pop in the same cycle: the record is dropped and overflow is set. Run state still advances as if the push succeeded.
  - Push and pop in the same cycle: both take effect; level unchanged; no overflow.
- Empty FIFO: out_ready is ignored; no underflow.
- fifo_level: +1 on push only, -1 on pop only, unchanged on both or neither.
- overflow and err are cleared only by reset.
- Length arithmetic is unsigned COUNT_WIDTH. No wrap past MAX; the saturation rule splits the run into multiple records.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1, in_code=1 -> out_valid=0, fifo_level=0, overflow=0, err=0 throughout; state stays IDLE after release with no input.
- Runs: with out_ready=1, sample 1,1,1,2,2, then flush -> out_valid rises the cycle after the 4th sample with record (1,3); after the flush, record (2,2); fifo_level returns to 0.
- Idle codes: sample 1,0,0,1, then flush -> exactly one record (1,2).
- Saturation (COUNT_WIDTH=8): 256 consecutive code-2 samples, then flush -> records (2,255) then (2,1).
- Backpressure (FIFO_DEPTH=4): out_ready=0, sample 1,2,1,2,1,2 -> fifo_level=4, overflow=1, records (1,1),(2,1),(1,1),(2,1) queued. Raise out_ready -> exactly those 4 drain in order; overflow stays 1. Repeat with out_ready=1 held in the cycle of the 5th push -> no drop.
- Reserved code and mid-run reset: sample 1,3,1 -> err=1, and after flush the record is (1,2). Next, queue 2 records while in RUN, then drive rst=0 mid-cycle -> out_valid=0, fifo_level=0, err=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/color_run_encoder.sv
// Run-length encoder for the colour FSM code stream: each maximal run of one
// code becomes a (code, length) record, queued in a small FIFO for the consumer.
module color_run_encoder #(
  parameter int COUNT_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     in_code,
  input  logic                           in_valid,
  input  logic                           flush,
  output logic [1:0]                     out_code,
  output logic [COUNT_WIDTH-1:0]         out_len,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                           overflow,
  output logic                           err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_LEN = {COUNT_WIDTH{1'b1}};
  localparam logic [LW-1:0]          FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef struct packed {
    logic [1:0]             code;
    logic [COUNT_WIDTH-1:0] len;
  } rec_t;

  state_e                 state_q, state_d;
  logic [1:0]             code_q, code_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   push;
  rec_t                   push_rec;

  // flush wins over any symbol presented in the same cycle
  logic sym, same, rsv;
  assign sym  = in_valid && !flush && (in_code == 2'd1 || in_code == 2'd2);
  assign rsv  = in_valid && !flush && (in_code == 2'd3);
  assign same = (in_code == code_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: if (sym) begin
        state_d = S_RUN;
        code_d  = in_code;
        len_d   = COUNT_WIDTH'(1);
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          len_d   = '0;
        end else if (sym) begin
          code_d = in_code;
          len_d  = (same && len_q != MAX_LEN) ? len_q + COUNT_WIDTH'(1) : COUNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A saturated run emits MAX and keeps going as a fresh run of the same code
  always_comb begin
    push     = 1'b0;
    push_rec = '{code: code_q, len: len_q};
    if (state_q == S_RUN)
      push = flush || (sym && (!same || len_q == MAX_LEN));
  end

  rec_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          full, pop, do_push;

  assign full    = (level_q == FULL_LVL);
  assign pop     = out_valid && out_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_rec;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({do_push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (push && !do_push) overflow <= 1'b1;
      if (rsv) err <= 1'b1;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_code   = out_valid ? mem_q[rd_q].code : 2'd0;
  assign out_len    = out_valid ? mem_q[rd_q].len : '0;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_color_run_encoder.sv
// Bench for color_run_encoder: directed table, hand sequences for multi-cycle
// corners, and random traffic checked against a queue-based reference model.
module tb_color_run_encoder;
  localparam int CW = 8;
  localparam int DEPTH = 4;
  localparam int MAXL = 255;

  logic clk, rst;
  logic [1:0] in_code;
  logic in_valid, flush, out_ready;
  logic [1:0] out_code;
  logic [CW-1:0] out_len;
  logic out_valid, overflow, err;
  logic [2:0] fifo_level;

  color_run_encoder #(.COUNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .flush(flush),
    .out_code(out_code), .out_len(out_len), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {logic [1:0] c; logic [7:0] l;} rec_t;
  rec_t mq[$];
  int m_code, m_len;
  bit m_ovf, m_err;

  function automatic logic [15:0] pk(bit v, logic [1:0] c, logic [7:0] l,
                                     logic [2:0] lev, bit ov, bit er);
    return {v, c, l, lev, ov, er};
  endfunction

  function automatic logic [15:0] obs();
    return {out_valid, out_code, out_len, fifo_level, overflow, err};
  endfunction

  function automatic logic [15:0] model_exp();
    if (mq.size() == 0) return pk(0, 0, 0, 0, m_ovf, m_err);
    return pk(1, mq[0].c, mq[0].l, 3'(mq.size()), m_ovf, m_err);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got {v,code,len,lvl,ovf,err}=%h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_code = 0; m_len = 0; m_ovf = 0; m_err = 0;
  endtask

  // One clock of the encoder rules using current inputs; the FIFO is a bounded queue
  task automatic model_cycle();
    rec_t r;
    bit pushf;
    pushf = 0;
    r = '0;
    if (flush) begin
      if (m_len > 0) begin pushf = 1; r = '{2'(m_code), 8'(m_len)}; end
      m_len = 0;
    end else if (in_valid) begin
      if (in_code == 3) m_err = 1;
      else if (in_code != 0) begin
        if (m_len > 0 && (int'(in_code) != m_code || m_len == MAXL)) begin
          pushf = 1; r = '{2'(m_code), 8'(m_len)};
        end
        if (m_len > 0 && int'(in_code) == m_code && m_len < MAXL) m_len++;
        else begin m_code = int'(in_code); m_len = 1; end
      end
    end
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (pushf) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input string name);
    model_cycle();
    @(posedge clk);
    #1;
    chk(name, obs(), model_exp());
  endtask

  task automatic drive(input bit v, input logic [1:0] c, input bit f, input bit rdy);
    in_valid = v; in_code = c; flush = f; out_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit v; logic [1:0] c; bit f; bit rdy;
    bit ev; logic [1:0] ec; logic [7:0] el; logic [2:0] elev;
  } vec_t;
  vec_t tv[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq6[6];
    int rmode;
    logic [1:0] rc;

    tv[0]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tv[1]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tv[3]  = '{1, 2, 0, 1, 1, 1, 3, 1};
    tv[4]  = '{1, 2, 0, 1, 0, 0, 0, 0};
    tv[5]  = '{0, 0, 1, 1, 1, 2, 2, 1};
    tv[6]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tv[7]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tv[8]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tv[9]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tv[10] = '{1, 1, 0, 1, 0, 0, 0, 0};
    tv[11] = '{0, 0, 1, 1, 1, 1, 2, 1};
    tv[12] = '{0, 0, 0, 1, 0, 0, 0, 0};
    tv[13] = '{1, 2, 1, 1, 0, 0, 0, 0};
    tv[14] = '{0, 0, 0, 1, 0, 0, 0, 0};
    tv[15] = '{0, 0, 1, 1, 0, 0, 0, 0};

    // reset held with live input
    rst = 1'b0;
    drive(1, 1, 0, 1);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", obs(), pk(0, 0, 0, 0, 0, 0));
    end
    rst = 1'b1;
    drive(0, 0, 0, 1);
    step("post_reset_idle");
    drive(0, 0, 1, 1);
    step("post_reset_flush");
    chk("post_reset_const", obs(), pk(0, 0, 0, 0, 0, 0));

    // directed table
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].v, tv[i].c, tv[i].f, tv[i].rdy);
      step($sformatf("table_model[%0d]", i));
      chk($sformatf("table[%0d]", i), obs(),
          pk(tv[i].ev, tv[i].ec, tv[i].el, tv[i].elev, 0, 0));
    end

    // saturation: 256 x code 2 then flush
    do_reset();
    drive(1, 2, 0, 0);
    for (int i = 0; i < 256; i++) step("sat_run");
    drive(0, 0, 1, 0);
    step("sat_flush");
    chk("sat_head0", obs(), pk(1, 2, 255, 2, 0, 0));
    drive(0, 0, 0, 1);
    step("sat_pop0");
    chk("sat_head1", obs(), pk(1, 2, 1, 1, 0, 0));
    step("sat_pop1");
    chk("sat_empty", obs(), pk(0, 0, 0, 0, 0, 0));

    // backpressure with one dropped record
    seq6[0] = 1; seq6[1] = 2; seq6[2] = 1; seq6[3] = 2; seq6[4] = 1; seq6[5] = 2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, seq6[i], 0, 0);
      step("bp_fill");
    end
    chk("bp_full_ovf", obs(), pk(1, 1, 1, 4, 1, 0));
    drive(0, 0, 0, 1);
    step("bp_drain0"); chk("bp_head1", obs(), pk(1, 2, 1, 3, 1, 0));
    step("bp_drain1"); chk("bp_head2", obs(), pk(1, 1, 1, 2, 1, 0));
    step("bp_drain2"); chk("bp_head3", obs(), pk(1, 2, 1, 1, 1, 0));
    step("bp_drain3"); chk("bp_drained", obs(), pk(0, 0, 0, 0, 1, 0));

    // full FIFO with a simultaneous pop: no drop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, seq6[i], 0, 0);
      step("bp2_fill");
    end
    chk("bp2_full", obs(), pk(1, 1, 1, 4, 0, 0));
    drive(1, 2, 0, 1);
    step("bp2_pushpop");
    chk("bp2_nodrop", obs(), pk(1, 2, 1, 4, 0, 0));

    // reserved code inside a run
    do_reset();
    drive(1, 1, 0, 0); step("rsv_a");
    drive(1, 3, 0, 0); step("rsv_b");
    drive(1, 1, 0, 0); step("rsv_c");
    drive(0, 0, 1, 0); step("rsv_flush");
    chk("rsv_rec", obs(), pk(1, 1, 2, 1, 0, 1));
    drive(1, 2, 0, 0); step("mr_a");
    drive(1, 1, 0, 0); step("mr_b");
    drive(1, 2, 0, 0); step("mr_c");
    chk("mr_queued", obs(), pk(1, 1, 2, 3, 0, 1));
    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset", obs(), pk(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("async_reset_hold", obs(), pk(0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    drive(0, 0, 0, 1);
    step("async_release");

    // random traffic
    do_reset();
    rmode = 2;
    rc = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) rmode = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 15))
          0, 1, 2, 3, 4, 5, 6:       rc = 2'd1;
          7, 8, 9, 10, 11, 12, 13:   rc = 2'd2;
          14:                        rc = 2'd0;
          default:                   rc = (i > 1500) ? 2'd3 : 2'd0;
        endcase
      end
      drive($urandom_range(0, 4) != 0, rc, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) < rmode);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
